// File: rtl/imem_loader.sv
// imem_loader: streams a program byte-by-byte into the instruction memory
// write port from address 0. The processor is held in reset while loading
// and released once the final byte has been written.
module imem_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] len_words,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [7:0]            checksum
);

    localparam logic [ADDR_WIDTH-2:0] MAX_LEN = (ADDR_WIDTH-1)'(MAX_WORDS);
    localparam logic [ADDR_WIDTH:0]   ONE     = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_t;

    state_t                state_q, state_d;
    // Byte counter and total carry one extra bit so a full 2^ADDR_WIDTH
    // byte load can be counted without the address ever wrapping.
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   total_q, total_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [7:0]            checksum_q, checksum_d;

    logic start_window;
    logic len_legal;
    logic start_ok;
    logic start_bad;
    logic accept;
    logic last_byte;

    // Start is only honoured outside an active load; the length is validated here.
    always_comb begin
        start_window = (state_q == IDLE) || (state_q == RUN);
        len_legal    = (len_words != '0) && (len_words <= MAX_LEN);
        start_ok     = start && start_window && len_legal;
        start_bad    = start && start_window && !len_legal;
        accept       = (state_q == LOAD) && in_valid;
        last_byte    = accept && (cnt_q == total_q - ONE);
    end

    // State and datapath registers, asynchronously reset to the idle state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            total_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
            checksum_q  <= checksum_d;
        end
    end

    // Next-state logic: load on a legal start, drain the last write, then run.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok)  state_d = LOAD;
            LOAD:    if (last_byte) state_d = DRAIN;
            DRAIN:                  state_d = RUN;
            RUN:     if (start_ok)  state_d = LOAD;
            default:                state_d = IDLE;
        endcase
    end

    // Datapath: count and checksum accepted bytes, register the write one cycle later.
    always_comb begin
        cnt_d       = cnt_q;
        total_d     = total_q;
        checksum_d  = checksum_q;
        mem_we_d    = accept;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (start_ok) begin
            cnt_d      = '0;
            total_d    = {len_words, 2'b00};
            checksum_d = '0;
        end else if (accept) begin
            cnt_d      = cnt_q + ONE;
            checksum_d = checksum_q ^ in_data;
        end
        if (accept) begin
            mem_addr_d  = cnt_q[ADDR_WIDTH-1:0];
            mem_wdata_d = in_data;
        end
        // The DRAIN->RUN edge is the only place done can fire, and start is
        // not evaluated in DRAIN, so done and error can never coincide.
        done_d  = (state_q == DRAIN);
        error_d = start_bad;
    end

    // Output decode: handshake, busy and processor reset follow the state alone.
    always_comb begin
        in_ready  = (state_q == LOAD);
        busy      = (state_q == LOAD) || (state_q == DRAIN);
        cpu_rst   = (state_q != RUN);
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        done      = done_q;
        error     = error_q;
        checksum  = checksum_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vectors for the instruction memory loader.
// A behavioural byte memory captures the write port so both the write order
// and the resulting contents can be checked.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] len_words;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  checksum;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  tb_mem [0:4095];
    logic [11:0] wr_a [$];
    logic [7:0]  wr_d [$];
    logic [7:0]  stream [0:63];
    logic [31:0] prog [0:12];

    int          done_edge;
    logic [7:0]  cks_at_done;
    logic        cpu_rst_at_done;
    logic        err_seen;

    imem_loader #(.ADDR_WIDTH(12), .MAX_WORDS(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len_words (len_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory model: commit each strobed byte and log the write.
    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr] = mem_wdata;
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cpu_rst"},  cpu_rst,   1);
        check({tag, "_in_ready"}, in_ready,  0);
        check({tag, "_mem_we"},   mem_we,    0);
        check({tag, "_mem_addr"}, mem_addr,  0);
        check({tag, "_wdata"},    mem_wdata, 0);
        check({tag, "_busy"},     busy,      0);
        check({tag, "_done"},     done,      0);
        check({tag, "_error"},    error,     0);
        check({tag, "_checksum"}, checksum,  0);
    endtask

    // Illegal-length start: one error cycle, nothing else changes.
    task automatic do_reject(input int lw, input logic exp_cpu_rst, input logic [7:0] exp_cks);
        @(negedge clk);
        start = 1'b1;
        len_words = 11'(lw);
        @(negedge clk);
        start = 1'b0;
        check("rej_error",    error,    1);
        check("rej_in_ready", in_ready, 0);
        check("rej_busy",     busy,     0);
        check("rej_cpu_rst",  cpu_rst,  exp_cpu_rst);
        check("rej_checksum", checksum, exp_cks);
        check("rej_done",     done,     0);
        @(negedge clk);
        check("rej_error_gone", error,   0);
        check("rej_cpu_rst2",   cpu_rst, exp_cpu_rst);
        check("rej_busy2",      busy,    0);
        $display("reject len_words=%0d applied", lw);
    endtask

    // Start a load of nwords words from stream[], optionally with gaps in
    // in_valid, and inject an ignored start during LOAD. Returns the edge
    // count (start edge = 0) at which done was first observed, or -1.
    task automatic do_load(input int nwords, input bit gaps);
        int idx;
        int edges;
        int budget;
        logic rdy;
        idx = 0;
        edges = 0;
        budget = nwords * 12 + 20;
        done_edge = -1;
        err_seen = 1'b0;
        wr_a.delete();
        wr_d.delete();
        @(negedge clk);
        start = 1'b1;
        len_words = 11'(nwords);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("load_entry_cpu_rst",  cpu_rst,  1);
        check("load_entry_in_ready", in_ready, 1);
        check("load_entry_busy",     busy,     1);
        check("load_entry_checksum", checksum, 0);
        while (done_edge < 0 && edges < budget) begin
            rdy = in_ready;
            start = (edges == 2);
            len_words = (edges == 2) ? 11'd5 : 11'(nwords);
            if (idx < nwords * 4) begin
                in_valid = gaps ? (edges % 2 == 1) : 1'b1;
                in_data = stream[idx];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            edges++;
            if (rdy && in_valid) idx++;
            @(negedge clk);
            start = 1'b0;
            if (error) err_seen = 1'b1;
            if (done) begin
                done_edge = edges;
                cks_at_done = checksum;
                cpu_rst_at_done = cpu_rst;
            end
        end
        in_valid = 1'b0;
        check("load_done_seen", (done_edge > 0), 1);
        check("start_in_load_no_error", err_seen, 0);
        $display("load of %0d words: %0d bytes sent, done at edge %0d", nwords, idx, done_edge);
    endtask

    // Compare the write log against stream[] at addresses 0..n-1.
    task automatic check_writes(input int nbytes);
        check("write_count", wr_a.size(), nbytes);
        for (int i = 0; i < nbytes && i < wr_a.size(); i++) begin
            check("write_addr", {20'd0, wr_a[i]}, i);
            check("write_data", {24'd0, wr_d[i]}, {24'd0, stream[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_cks;
        prog[0]  = 32'h200900C8; prog[1]  = 32'h212AFF9C; prog[2]  = 32'h01495020;
        prog[3]  = 32'h012A582A; prog[4]  = 32'h11600002; prog[5]  = 32'h214A0001;
        prog[6]  = 32'h08000007; prog[7]  = 32'hAC0A0040; prog[8]  = 32'h8C0B0040;
        prog[9]  = 32'h016B6020; prog[10] = 32'h000C6880; prog[11] = 32'h01AD7025;
        prog[12] = 32'h20080005;
        for (int i = 0; i < 4096; i++) tb_mem[i] = 8'h00;

        rst = 1'b1;
        start = 1'b0;
        len_words = '0;
        in_valid = 1'b0;
        in_data = '0;

        // Reset values appear before any clock edge.
        #2;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");

        // Rejections from IDLE.
        do_reject(0, 1'b1, 8'h00);
        do_reject(1025, 1'b1, 8'h00);

        // Full program, contiguous stream, big-endian byte order.
        exp_cks = 8'h00;
        for (int w = 0; w < 13; w++) begin
            for (int b = 0; b < 4; b++) begin
                stream[w*4+b] = prog[w][31-8*b -: 8];
                exp_cks ^= prog[w][31-8*b -: 8];
            end
        end
        do_load(13, 1'b0);
        check("prog_done_edge", done_edge, 53);
        check("prog_cpu_rst_at_done", cpu_rst_at_done, 0);
        check("prog_checksum", cks_at_done, exp_cks);
        check_writes(52);
        check("prog_fetch_pc0", {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]}, 32'h200900C8);
        check("prog_fetch_last", {tb_mem[48], tb_mem[49], tb_mem[50], tb_mem[51]}, 32'h20080005);
        check("prog_untouched_52", tb_mem[52], 8'h00);
        @(negedge clk);
        check("prog_done_pulse_1cyc", done, 0);
        check("prog_run_cpu_rst", cpu_rst, 0);

        // Gapped stream DE AD BE EF.
        stream[0] = 8'hDE; stream[1] = 8'hAD; stream[2] = 8'hBE; stream[3] = 8'hEF;
        do_load(1, 1'b1);
        check("gap_checksum", cks_at_done, 8'h22);
        check("gap_cpu_rst_at_done", cpu_rst_at_done, 0);
        check_writes(4);
        check("gap_mem4_kept", tb_mem[4], 8'h21);

        // Rejection from RUN keeps the processor running and checksum intact.
        do_reject(1025, 1'b0, 8'h22);

        // Reload from RUN with two words.
        for (int i = 0; i < 8; i++) stream[i] = 8'h11 + 8'(i);
        do_load(2, 1'b0);
        check("reload_done_edge", done_edge, 9);
        check("reload_cpu_rst_at_done", cpu_rst_at_done, 0);
        check("reload_checksum", cks_at_done, 8'h11 ^ 8'h12 ^ 8'h13 ^ 8'h14 ^ 8'h15 ^ 8'h16 ^ 8'h17 ^ 8'h18);
        check_writes(8);

        // Reset mid-load: six bytes accepted, sixth write still pending.
        wr_a.delete();
        wr_d.delete();
        @(negedge clk);
        start = 1'b1;
        len_words = 11'd2;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data = 8'h40 + 8'(c);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("midload_pending_we", mem_we, 1);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("midload_reset");
        @(negedge clk);
        rst = 1'b0;
        check("midload_write_count", wr_a.size(), 5);
        check("midload_mem0", tb_mem[0], 8'h40);
        check("midload_mem4", tb_mem[4], 8'h44);
        check("midload_mem5_kept", tb_mem[5], 8'h16);
        $display("reset during load applied after 6 accepted bytes");

        // Fresh load after the abort starts at address 0 with a clean checksum.
        stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h04; stream[3] = 8'h08;
        do_load(1, 1'b0);
        check("restart_checksum", cks_at_done, 8'h0F);
        check_writes(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
